prim_ram_scrubber: RTL

PRIM_RAM_SCRUBBER -- requirements
Module: prim_ram_scrubber

---
 rtl/prim_ram_scrubber_pkg.sv | 16 +
 rtl/prim_ram_scrubber_sat_cnt.sv | 24 ++
 rtl/prim_ram_scrubber.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/prim_ram_scrubber_pkg.sv
// Shared types for the SRAM scrubber: FSM state encoding and response error bit positions.
package prim_ram_scrubber_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StRead,
        StResp,
        StWback
    } scrub_state_e;

    // Bit positions within the 2-bit read response error code.
    localparam int unsigned ErrCorrBit   = 0;
    localparam int unsigned ErrUncorrBit = 1;

endpackage

// File: rtl/prim_ram_scrubber_sat_cnt.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module prim_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Count up, holding once every bit is set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prim_ram_scrubber.sv
// Background SRAM scrubber: walks every word, reads it, writes back corrected data on a
// correctable ECC error, and logs uncorrectable errors. One request outstanding at a time.
module prim_ram_scrubber
    import prim_ram_scrubber_pkg::*;
#(
    parameter int unsigned Depth  = 512,
    parameter int unsigned Width  = 32,
    parameter int unsigned IntW   = 16,
    parameter int unsigned CntW   = 16,
    parameter int unsigned SramAw = $clog2(Depth)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [IntW-1:0]   interval_i,
    input  logic              gnt_i,
    output logic              req_o,
    output logic              write_o,
    output logic [SramAw-1:0] addr_o,
    output logic [Width-1:0]  wdata_o,
    input  logic              rvalid_i,
    input  logic [Width-1:0]  rdata_i,
    input  logic [1:0]        rerror_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CntW-1:0]   corr_cnt_o,
    output logic [CntW-1:0]   uncorr_cnt_o,
    output logic              uncorr_o,
    output logic [SramAw-1:0] uncorr_addr_o
);

    localparam logic [SramAw-1:0] LastAddr = SramAw'(Depth - 1);

    scrub_state_e      state_q;
    logic [SramAw-1:0] addr_q;
    logic [SramAw-1:0] addr_next;
    logic              addr_last;
    logic [IntW-1:0]   int_cnt_q;
    logic              req_q;
    logic              write_q;
    logic [Width-1:0]  wdata_q;
    logic              done_q;
    logic              uncorr_q;
    logic [SramAw-1:0] uncorr_addr_q;
    logic              rsp_fire;
    logic              corr_inc;
    logic              uncorr_inc;

    // Responses only count while a read is outstanding; an uncorrectable flag overrides
    // the correctable one.
    assign rsp_fire   = (state_q == StResp) && rvalid_i;
    assign uncorr_inc = rsp_fire && rerror_i[ErrUncorrBit];
    assign corr_inc   = rsp_fire && (rerror_i == 2'b01);

    assign addr_last = (addr_q == LastAddr);
    assign addr_next = addr_last ? '0 : addr_q + SramAw'(1);

    // Scrub FSM with registered SRAM request and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            int_cnt_q     <= '0;
            req_q         <= 1'b0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            done_q        <= 1'b0;
            uncorr_q      <= 1'b0;
            uncorr_addr_q <= '0;
        end else begin
            done_q   <= 1'b0;
            uncorr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (en_i) begin
                        state_q   <= StWait;
                        int_cnt_q <= interval_i;
                    end
                end
                StWait: begin
                    if (!en_i) begin
                        state_q <= StIdle;
                    end else if (int_cnt_q == '0) begin
                        state_q <= StRead;
                        req_q   <= 1'b1;
                        write_q <= 1'b0;
                    end else begin
                        int_cnt_q <= int_cnt_q - IntW'(1);
                    end
                end
                StRead: begin
                    // A grant in the same cycle as a disable still commits the read.
                    if (gnt_i) begin
                        state_q <= StResp;
                        req_q   <= 1'b0;
                    end else if (!en_i) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                    end
                end
                StResp: begin
                    if (rsp_fire) begin
                        if (uncorr_inc) begin
                            uncorr_q      <= 1'b1;
                            uncorr_addr_q <= addr_q;
                        end
                        if (corr_inc) begin
                            state_q <= StWback;
                            wdata_q <= rdata_i;
                            req_q   <= 1'b1;
                            write_q <= 1'b1;
                        end else begin
                            addr_q    <= addr_next;
                            done_q    <= addr_last;
                            int_cnt_q <= interval_i;
                            state_q   <= en_i ? StWait : StIdle;
                        end
                    end
                end
                StWback: begin
                    if (gnt_i) begin
                        req_q     <= 1'b0;
                        write_q   <= 1'b0;
                        addr_q    <= addr_next;
                        done_q    <= addr_last;
                        int_cnt_q <= interval_i;
                        state_q   <= en_i ? StWait : StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    prim_sat_cnt #(
        .W(CntW)
    ) u_corr_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .inc_i (corr_inc),
        .cnt_o (corr_cnt_o)
    );

    prim_sat_cnt #(
        .W(CntW)
    ) u_uncorr_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .inc_i (uncorr_inc),
        .cnt_o (uncorr_cnt_o)
    );

    assign req_o         = req_q;
    assign write_o       = write_q;
    assign addr_o        = addr_q;
    assign wdata_o       = wdata_q;
    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;
    assign uncorr_o      = uncorr_q;
    assign uncorr_addr_o = uncorr_addr_q;

endmodule
